// File: rtl/stage_id_pipe_pkg.sv
// Decode constants, condition codes and control payload shared by the ID stage.
package id_pkg;

    localparam int unsigned INST_W    = 32;
    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned ALU_CMD_W = 4;
    localparam int unsigned NUM_REGS  = 15;

    localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

    // Bit positions of {N,Z,C,V} in the status word
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        MODE_DP     = 2'b00,
        MODE_MEM    = 2'b01,
        MODE_BRANCH = 2'b10,
        MODE_COPROC = 2'b11
    } mode_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [ALU_CMD_W-1:0] ALU_NOP = 4'b0000;
    localparam logic [ALU_CMD_W-1:0] ALU_MOV = 4'b0001;
    localparam logic [ALU_CMD_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CMD_W-1:0] ALU_ADC = 4'b0011;
    localparam logic [ALU_CMD_W-1:0] ALU_SUB = 4'b0100;
    localparam logic [ALU_CMD_W-1:0] ALU_SBC = 4'b0101;
    localparam logic [ALU_CMD_W-1:0] ALU_AND = 4'b0110;
    localparam logic [ALU_CMD_W-1:0] ALU_ORR = 4'b0111;
    localparam logic [ALU_CMD_W-1:0] ALU_EOR = 4'b1000;
    localparam logic [ALU_CMD_W-1:0] ALU_MVN = 4'b1001;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001,
        COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101,
        COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001,
        COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101,
        COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    typedef struct packed {
        logic [ALU_CMD_W-1:0] aluCmd;
        logic                 memRead;
        logic                 memWrite;
        logic                 wbEn;
        logic                 branch;
        logic                 s;
    } ctrl_t;

    // Evaluate a condition field against the {N,Z,C,V} flags
    function automatic logic condPass(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        case (cond_e'(cond))
            COND_EQ: condPass = z;
            COND_NE: condPass = ~z;
            COND_CS: condPass = c;
            COND_CC: condPass = ~c;
            COND_MI: condPass = n;
            COND_PL: condPass = ~n;
            COND_VS: condPass = v;
            COND_VC: condPass = ~v;
            COND_HI: condPass = c & ~z;
            COND_LS: condPass = ~c | z;
            COND_GE: condPass = (n == v);
            COND_LT: condPass = (n != v);
            COND_GT: condPass = ~z & (n == v);
            COND_LE: condPass = z | (n != v);
            COND_AL: condPass = 1'b1;
            default: condPass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stage_id_pipe_reg_file_bypass.sv
// 15-entry register file with two read ports; index 15 reads the PC and an
// optional same-cycle write-back bypass feeds the read ports.
module reg_file_bypass
    import id_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter bit          BYPASS_WB = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    pc,
    input  logic [REG_IDX_W-1:0] rdIdxA,
    input  logic [REG_IDX_W-1:0] rdIdxB,
    output logic [DATA_W-1:0]    rdDataA,
    output logic [DATA_W-1:0]    rdDataB,
    input  logic                 wrEn,
    input  logic [REG_IDX_W-1:0] wrIdx,
    input  logic [DATA_W-1:0]    wrData
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Writes to the PC slot are dropped; there is no storage behind it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn && (wrIdx != PC_IDX)) begin
            regs[wrIdx] <= wrData;
        end
    end

    always_comb begin
        rdDataA = '0;
        if (rdIdxA == PC_IDX) begin
            rdDataA = pc;
        end else if (BYPASS_WB && wrEn && (wrIdx == rdIdxA)) begin
            rdDataA = wrData;
        end else begin
            rdDataA = regs[rdIdxA];
        end
    end

    always_comb begin
        rdDataB = '0;
        if (rdIdxB == PC_IDX) begin
            rdDataB = pc;
        end else if (BYPASS_WB && wrEn && (wrIdx == rdIdxB)) begin
            rdDataB = wrData;
        end else begin
            rdDataB = regs[rdIdxB];
        end
    end

endmodule

// File: rtl/stage_id_pipe.sv
// Decode stage with register read and the ID/EX pipeline register; supports
// bubble (hazard), flush and freeze of the ID/EX slot.
module stage_id_pipe
    import id_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter bit          BYPASS_WB = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    pcIn,
    input  logic [INST_W-1:0]    inst,
    input  logic                 instValid,
    input  logic [3:0]           status,
    input  logic                 wbWbEn,
    input  logic [REG_IDX_W-1:0] wbDest,
    input  logic [DATA_W-1:0]    wbValue,
    input  logic                 hazard,
    input  logic                 flush,
    input  logic                 freeze,
    output logic                 hazardTwoSrc,
    output logic [REG_IDX_W-1:0] srcA,
    output logic [REG_IDX_W-1:0] srcB,
    output logic                 outValid,
    output logic [ALU_CMD_W-1:0] aluCmd,
    output logic                 memRead,
    output logic                 memWrite,
    output logic                 wbEn,
    output logic                 branch,
    output logic                 s,
    output logic [DATA_W-1:0]    pcOut,
    output logic [DATA_W-1:0]    valRn,
    output logic [DATA_W-1:0]    valRm,
    output logic                 imm,
    output logic [11:0]          shiftOperand,
    output logic [23:0]          imm24,
    output logic [REG_IDX_W-1:0] dest,
    output logic [REG_IDX_W-1:0] src1,
    output logic [REG_IDX_W-1:0] src2
);

    mode_e                mode;
    logic                 immBit;
    logic                 sBit;
    logic [3:0]           opcode;
    logic [REG_IDX_W-1:0] rn;
    logic [REG_IDX_W-1:0] rd;
    ctrl_t                decCtrl;
    logic                 dpKnown;
    logic                 kill;
    logic [DATA_W-1:0]    rdValA;
    logic [DATA_W-1:0]    rdValB;
    ctrl_t                ctrlQ;
    logic                 validQ;

    assign mode   = mode_e'(inst[27:26]);
    assign immBit = inst[25];
    assign opcode = inst[24:21];
    assign sBit   = inst[20];
    assign rn     = inst[19:16];
    assign rd     = inst[15:12];

    // Instruction decode; unknown data-processing opcodes decode to all-zero control
    always_comb begin
        decCtrl = '0;
        dpKnown = 1'b0;
        case (mode)
            MODE_DP: begin
                dpKnown = 1'b1;
                case (opcode)
                    OP_MOV:  begin decCtrl.aluCmd = ALU_MOV; decCtrl.wbEn = 1'b1; end
                    OP_MVN:  begin decCtrl.aluCmd = ALU_MVN; decCtrl.wbEn = 1'b1; end
                    OP_ADD:  begin decCtrl.aluCmd = ALU_ADD; decCtrl.wbEn = 1'b1; end
                    OP_ADC:  begin decCtrl.aluCmd = ALU_ADC; decCtrl.wbEn = 1'b1; end
                    OP_SUB:  begin decCtrl.aluCmd = ALU_SUB; decCtrl.wbEn = 1'b1; end
                    OP_SBC:  begin decCtrl.aluCmd = ALU_SBC; decCtrl.wbEn = 1'b1; end
                    OP_AND:  begin decCtrl.aluCmd = ALU_AND; decCtrl.wbEn = 1'b1; end
                    OP_ORR:  begin decCtrl.aluCmd = ALU_ORR; decCtrl.wbEn = 1'b1; end
                    OP_EOR:  begin decCtrl.aluCmd = ALU_EOR; decCtrl.wbEn = 1'b1; end
                    OP_CMP:  decCtrl.aluCmd = ALU_SUB;
                    OP_TST:  decCtrl.aluCmd = ALU_AND;
                    default: dpKnown = 1'b0;
                endcase
                decCtrl.s = dpKnown & sBit;
            end
            MODE_MEM: begin
                decCtrl.aluCmd = ALU_ADD;
                if (sBit) begin
                    decCtrl.memRead = 1'b1;
                    decCtrl.wbEn    = 1'b1;
                end else begin
                    decCtrl.memWrite = 1'b1;
                end
            end
            MODE_BRANCH: decCtrl.branch = 1'b1;
            default: decCtrl = '0;
        endcase
    end

    // Stores read Rd as the second operand (the value to be stored)
    assign srcA         = rn;
    assign srcB         = decCtrl.memWrite ? rd : inst[3:0];
    assign hazardTwoSrc = instValid & (~immBit | decCtrl.memWrite);
    assign kill         = ~instValid | ~condPass(inst[31:28], status);

    reg_file_bypass #(
        .DATA_W    (DATA_W),
        .BYPASS_WB (BYPASS_WB)
    ) u_regFile (
        .clk     (clk),
        .rst     (rst),
        .pc      (pcIn),
        .rdIdxA  (srcA),
        .rdIdxB  (srcB),
        .rdDataA (rdValA),
        .rdDataB (rdValB),
        .wrEn    (wbWbEn),
        .wrIdx   (wbDest),
        .wrData  (wbValue)
    );

    // ID/EX slot: flush beats freeze, freeze beats hazard; bubbles keep data fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validQ       <= 1'b0;
            ctrlQ        <= '0;
            pcOut        <= '0;
            valRn        <= '0;
            valRm        <= '0;
            imm          <= 1'b0;
            shiftOperand <= '0;
            imm24        <= '0;
            dest         <= '0;
            src1         <= '0;
            src2         <= '0;
        end else if (flush || (hazard && !freeze)) begin
            validQ <= 1'b0;
            ctrlQ  <= '0;
        end else if (!freeze) begin
            validQ       <= ~kill;
            ctrlQ        <= kill ? ctrl_t'('0) : decCtrl;
            pcOut        <= pcIn;
            valRn        <= rdValA;
            valRm        <= rdValB;
            imm          <= immBit;
            shiftOperand <= inst[11:0];
            imm24        <= inst[23:0];
            dest         <= rd;
            src1         <= srcA;
            src2         <= srcB;
        end
    end

    assign outValid = validQ;
    assign aluCmd   = ctrlQ.aluCmd;
    assign memRead  = ctrlQ.memRead;
    assign memWrite = ctrlQ.memWrite;
    assign wbEn     = ctrlQ.wbEn;
    assign branch   = ctrlQ.branch;
    assign s        = ctrlQ.s;

endmodule

// File: tb/tb_stage_id_pipe.sv
// Scoreboard bench for stage_id_pipe: one instance with write-back bypass and
// one without, both driven by the same stimulus and checked against a reference model.
module tb_stage_id_pipe;

    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [3:0]        aluCmd;
        logic              memRead;
        logic              memWrite;
        logic              wbEn;
        logic              branch;
        logic              s;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] valRn;
        logic [DATA_W-1:0] valRm;
        logic              imm;
        logic [11:0]       shiftOperand;
        logic [23:0]       imm24;
        logic [3:0]        dest;
        logic [3:0]        src1;
        logic [3:0]        src2;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] pcIn;
    logic [31:0]       inst;
    logic              instValid;
    logic [3:0]        status;
    logic              wbWbEn;
    logic [3:0]        wbDest;
    logic [DATA_W-1:0] wbValue;
    logic              hazard;
    logic              flush;
    logic              freeze;

    // Index 1: bypass enabled, index 0: bypass disabled
    logic              oHz [2];
    logic [3:0]        oSrcA [2];
    logic [3:0]        oSrcB [2];
    logic              oValid [2];
    logic [3:0]        oAlu [2];
    logic              oMr [2];
    logic              oMw [2];
    logic              oWb [2];
    logic              oBr [2];
    logic              oS [2];
    logic [DATA_W-1:0] oPc [2];
    logic [DATA_W-1:0] oRn [2];
    logic [DATA_W-1:0] oRm [2];
    logic              oImm [2];
    logic [11:0]       oShift [2];
    logic [23:0]       oImm24 [2];
    logic [3:0]        oDest [2];
    logic [3:0]        oSrc1 [2];
    logic [3:0]        oSrc2 [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        stage_id_pipe #(
            .DATA_W    (DATA_W),
            .BYPASS_WB (k == 1)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .pcIn         (pcIn),
            .inst         (inst),
            .instValid    (instValid),
            .status       (status),
            .wbWbEn       (wbWbEn),
            .wbDest       (wbDest),
            .wbValue      (wbValue),
            .hazard       (hazard),
            .flush        (flush),
            .freeze       (freeze),
            .hazardTwoSrc (oHz[k]),
            .srcA         (oSrcA[k]),
            .srcB         (oSrcB[k]),
            .outValid     (oValid[k]),
            .aluCmd       (oAlu[k]),
            .memRead      (oMr[k]),
            .memWrite     (oMw[k]),
            .wbEn         (oWb[k]),
            .branch       (oBr[k]),
            .s            (oS[k]),
            .pcOut        (oPc[k]),
            .valRn        (oRn[k]),
            .valRm        (oRm[k]),
            .imm          (oImm[k]),
            .shiftOperand (oShift[k]),
            .imm24        (oImm24[k]),
            .dest         (oDest[k]),
            .src1         (oSrc1[k]),
            .src2         (oSrc2[k])
        );
    end

    int nChecks = 0;
    int nErrors = 0;

    // Reference state: architectural registers and the expected ID/EX contents
    logic [DATA_W-1:0] mRegs [15];
    out_t              mState [2];
    out_t              expQ0 [$];
    out_t              expQ1 [$];

    // aluCmd per data-processing opcode; -1 marks an undefined opcode
    int dpAlu [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    function automatic out_t getAct(input int k);
        out_t a;
        a.valid        = oValid[k];
        a.aluCmd       = oAlu[k];
        a.memRead      = oMr[k];
        a.memWrite     = oMw[k];
        a.wbEn         = oWb[k];
        a.branch       = oBr[k];
        a.s            = oS[k];
        a.pc           = oPc[k];
        a.valRn        = oRn[k];
        a.valRm        = oRm[k];
        a.imm          = oImm[k];
        a.shiftOperand = oShift[k];
        a.imm24        = oImm24[k];
        a.dest         = oDest[k];
        a.src1         = oSrc1[k];
        a.src2         = oSrc2[k];
        return a;
    endfunction

    task automatic cmpOut(input string name, input out_t a, input out_t e);
        nChecks++;
        if (a !== e) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    // ARM conditions come in complementary pairs selected by the low bit
    function automatic bit refCond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [DATA_W-1:0] refRead(input logic [3:0] idx, input bit byp);
        if (idx == 4'd15) return pcIn;
        if (byp && wbWbEn && (wbDest == idx)) return wbValue;
        return mRegs[idx];
    endfunction

    // Check combinational outputs, advance the model by one clock and queue expectations
    task automatic modelCycle();
        bit         isStr, kill;
        logic [3:0] expSrcB;
        bit         expHz;
        out_t       dec, nxt;
        int         op;

        isStr   = (inst[27:26] == 2'b01) && !inst[20];
        expSrcB = isStr ? inst[15:12] : inst[3:0];
        expHz   = instValid && (!inst[25] || isStr);
        for (int k = 0; k < 2; k++) begin
            nChecks++;
            if ({oHz[k], oSrcA[k], oSrcB[k]} !== {expHz, inst[19:16], expSrcB}) begin
                nErrors++;
                $display("FAIL comb[%0d]: got hz=%b srcA=%h srcB=%h expected hz=%b srcA=%h srcB=%h",
                         k, oHz[k], oSrcA[k], oSrcB[k], expHz, inst[19:16], expSrcB);
            end
        end

        dec = '0;
        op  = int'(inst[24:21]);
        case (inst[27:26])
            2'b00: if (dpAlu[op] >= 0) begin
                dec.aluCmd = 4'(dpAlu[op]);
                dec.wbEn   = !(op == 8 || op == 10);
                dec.s      = inst[20];
            end
            2'b01: begin
                dec.aluCmd   = 4'd2;
                dec.memRead  = inst[20];
                dec.wbEn     = inst[20];
                dec.memWrite = !inst[20];
            end
            2'b10: dec.branch = 1'b1;
            default: dec = '0;
        endcase
        kill = !instValid || !refCond(inst[31:28], status);

        for (int k = 0; k < 2; k++) begin
            nxt = mState[k];
            if (flush || (!freeze && hazard)) begin
                {nxt.valid, nxt.aluCmd, nxt.memRead, nxt.memWrite, nxt.wbEn, nxt.branch, nxt.s} = '0;
            end else if (!freeze) begin
                nxt              = kill ? out_t'('0) : dec;
                nxt.valid        = !kill;
                nxt.pc           = pcIn;
                nxt.valRn        = refRead(inst[19:16], k == 1);
                nxt.valRm        = refRead(expSrcB, k == 1);
                nxt.imm          = inst[25];
                nxt.shiftOperand = inst[11:0];
                nxt.imm24        = inst[23:0];
                nxt.dest         = inst[15:12];
                nxt.src1         = inst[19:16];
                nxt.src2         = expSrcB;
            end
            mState[k] = nxt;
        end
        expQ0.push_back(mState[0]);
        expQ1.push_back(mState[1]);

        if (wbWbEn && wbDest != 4'd15) mRegs[wbDest] = wbValue;
    endtask

    task automatic step(input logic [31:0] i, input bit iv, input logic [3:0] st,
                        input bit we, input logic [3:0] wd, input logic [DATA_W-1:0] wv,
                        input logic [DATA_W-1:0] pc, input bit hz, input bit fl, input bit fz);
        inst = i; instValid = iv; status = st;
        wbWbEn = we; wbDest = wd; wbValue = wv; pcIn = pc;
        hazard = hz; flush = fl; freeze = fz;
        #1;
        modelCycle();
        @(negedge clk);
    endtask

    task automatic randomStep();
        logic [31:0] i;
        logic [3:0]  wd;
        i = $urandom();
        if ($urandom_range(0, 1) == 1) i[31:28] = 4'hE;
        if ($urandom_range(0, 5) == 0) i[19:16] = 4'hF;
        if ($urandom_range(0, 3) == 0) i[27:26] = 2'b01;
        wd = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) wd = i[19:16];
        step(i, $urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)),
             $urandom_range(0, 1) == 1, wd, $urandom(), $urandom(),
             $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
    endtask

    // Asynchronous reset pulsed between clock edges; outputs must clear at once
    task automatic doReset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        cmpOut("reset_byp0", getAct(0), '0);
        cmpOut("reset_byp1", getAct(1), '0);
        for (int r = 0; r < 15; r++) mRegs[r] = '0;
        mState[0] = '0;
        mState[1] = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every rising edge the ID/EX slot presents the next queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ0.size() > 0) cmpOut("idex_byp0", getAct(0), expQ0.pop_front());
            if (expQ1.size() > 0) cmpOut("idex_byp1", getAct(1), expQ1.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        inst = '0; instValid = 1'b0; status = '0; pcIn = '0;
        wbWbEn = 1'b0; wbDest = '0; wbValue = '0;
        hazard = 1'b0; flush = 1'b0; freeze = 1'b0;
        for (int r = 0; r < 15; r++) mRegs[r] = '0;
        mState[0] = '0;
        mState[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        cmpOut("init_reset_byp0", getAct(0), '0);
        cmpOut("init_reset_byp1", getAct(1), '0);
        @(negedge clk);
        rst = 1'b0;

        // ADD R1,R2,R3 while R2<=5 is written back in the same cycle
        step(32'hE0821003, 1, 4'h0, 1, 4'd2, 32'd5, 32'h100, 0, 0, 0);
        // MOVEQ R5,#7 with Z clear, then Z set
        step(32'h03A05007, 1, 4'b0000, 0, 4'd0, 32'd0, 32'h104, 0, 0, 0);
        step(32'h03A05007, 1, 4'b0100, 0, 4'd0, 32'd0, 32'h108, 0, 0, 0);
        // STR R4,[R15,#8]
        step(32'hE58F4008, 1, 4'h0, 0, 4'd0, 32'd0, 32'h10C, 0, 0, 0);
        // Bubble, freeze+hazard hold, flush+freeze kill
        step(32'hE0821003, 1, 4'h0, 0, 4'd0, 32'd0, 32'h110, 1, 0, 0);
        step(32'hE0821003, 1, 4'h0, 0, 4'd0, 32'd0, 32'h114, 0, 0, 0);
        step(32'hE0821003, 1, 4'h0, 0, 4'd0, 32'd0, 32'h118, 1, 0, 1);
        step(32'hE0821003, 1, 4'h0, 0, 4'd0, 32'd0, 32'h11C, 0, 1, 1);
        // Write to R15 is ignored; R15 reads keep returning the PC
        step(32'hE0000000, 1, 4'h0, 1, 4'd15, 32'hDEAD, 32'h120, 0, 0, 0);
        step(32'hE08F100F, 1, 4'h0, 0, 4'd0, 32'd0, 32'h124, 0, 0, 0);

        doReset();
        // Read R3 right after reset
        step(32'hE0831000, 1, 4'h0, 0, 4'd0, 32'd0, 32'h200, 0, 0, 0);

        repeat (1500) randomStep();
        doReset();
        repeat (1500) randomStep();

        for (int w = 0; w < 10 && (expQ0.size() > 0 || expQ1.size() > 0); w++) @(negedge clk);
        if (expQ0.size() > 0 || expQ1.size() > 0) begin
            nChecks++;
            nErrors++;
            $display("FAIL drain: got %0d/%0d pending expected 0", expQ0.size(), expQ1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
